// File: rtl/acq_ring_writer.sv
// Acquisition ring writer: buffers a sample stream and writes it into a circular memory region
// as AXI INCR bursts, one burst outstanding at a time.
module acq_ring_writer #(
    parameter int unsigned AXI_WIDTH  = 32,
    parameter int unsigned AXI_ADDRS  = 27,
    parameter int unsigned AXI_IDNUM  = 4,
    parameter int unsigned ACQ_ID     = 1,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   aresetn,
    input  logic                   enable_i,
    input  logic [AXI_ADDRS-1:0]   base_i,
    input  logic [AXI_ADDRS-1:0]   size_i,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [AXI_WIDTH-1:0]   s_tdata,
    output logic                   axi_awvalid_o,
    input  logic                   axi_awready_i,
    output logic [AXI_ADDRS-1:0]   axi_awaddr_o,
    output logic [AXI_IDNUM-1:0]   axi_awid_o,
    output logic [7:0]             axi_awlen_o,
    output logic [1:0]             axi_awburst_o,
    output logic                   axi_wvalid_o,
    input  logic                   axi_wready_i,
    output logic                   axi_wlast_o,
    output logic [AXI_WIDTH/8-1:0] axi_wstrb_o,
    output logic [AXI_WIDTH-1:0]   axi_wdata_o,
    input  logic                   axi_bvalid_i,
    output logic                   axi_bready_o,
    input  logic [1:0]             axi_bresp_i,
    output logic [1:0]             status_o,
    output logic [15:0]            bursts_o
);

    localparam int unsigned BYTES = AXI_WIDTH / 8;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned AW1   = AXI_ADDRS + 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e state_q, state_d;

    logic [AXI_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic                 enable_q, flush_q, flush_d, alive_q;
    logic [AXI_ADDRS-1:0] addr_q, base_q, size_q;
    logic [8:0]           len_q, len_d, beat_q;
    logic [1:0]           status_q;
    logic [15:0]          bursts_q;

    logic           full, empty, en_rise, en_fall, arm, push, pop, beat_last, resp_done;
    logic [AW1-1:0] next_addr, ring_end;

    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign en_rise   = enable_i & ~enable_q;
    assign en_fall   = ~enable_i & enable_q;
    assign arm       = en_rise && (state_q == StIdle) && empty;
    assign s_tready  = alive_q && !full;
    assign push      = s_tvalid && s_tready && enable_i;
    assign pop       = (state_q == StData) && axi_wready_i;
    assign beat_last = (beat_q == len_q - 9'd1);
    assign resp_done = (state_q == StResp) && axi_bvalid_i;

    assign next_addr = AW1'(addr_q) + AW1'(len_q) * AW1'(BYTES);
    assign ring_end  = AW1'(base_q) + AW1'(size_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            StIdle: begin
                if (level_q >= LVL_W'(BURST_LEN)) begin
                    len_d   = 9'(BURST_LEN);
                    state_d = StAddr;
                end else if (flush_q && !empty) begin
                    len_d   = 9'(level_q);
                    state_d = StAddr;
                end
            end
            StAddr: if (axi_awready_i) state_d = StData;
            StData: if (axi_wready_i && beat_last) state_d = StResp;
            StResp: if (axi_bvalid_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A push in the same cycle keeps the flag alive so a lone s_tlast word still gets written.
    always_comb begin
        flush_d = flush_q | en_fall | (push & s_tlast);
        if ((state_q == StIdle) && empty && !push) flush_d = 1'b0;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            enable_q <= 1'b0;
            flush_q  <= 1'b0;
            alive_q  <= 1'b0;
            addr_q   <= '0;
            base_q   <= '0;
            size_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            status_q <= '0;
            bursts_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            enable_q <= enable_i;
            flush_q  <= flush_d;
            alive_q  <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (!push && pop) level_q <= level_q - LVL_W'(1);
            if (state_q != StData) beat_q <= '0;
            else if (pop)          beat_q <= beat_q + 9'd1;
            if (arm) begin
                addr_q   <= base_i;
                base_q   <= base_i;
                size_q   <= size_i;
                status_q <= '0;
                bursts_q <= '0;
            end else begin
                if (s_tvalid && !s_tready && enable_i) status_q[1] <= 1'b1;
                if (resp_done) begin
                    bursts_q <= bursts_q + 16'd1;
                    if (axi_bresp_i != 2'b00) status_q[0] <= 1'b1;
                    addr_q <= (next_addr >= ring_end) ? base_q : next_addr[AXI_ADDRS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= s_tdata;
    end

    assign axi_awvalid_o = (state_q == StAddr);
    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = AXI_IDNUM'(ACQ_ID);
    assign axi_awlen_o   = axi_awvalid_o ? 8'(len_q - 9'd1) : 8'd0;
    assign axi_awburst_o = 2'b01;
    assign axi_wvalid_o  = (state_q == StData);
    assign axi_wlast_o   = axi_wvalid_o && beat_last;
    assign axi_wstrb_o   = {BYTES{axi_wvalid_o}};
    assign axi_wdata_o   = axi_wvalid_o ? mem[rd_ptr_q] : '0;
    assign axi_bready_o  = (state_q == StResp);
    assign status_o      = status_q;
    assign bursts_o      = bursts_q;

endmodule
